// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the MEM stage / EXT requester / data memory and the arbiter.
// The slave modport is the arbiter's view; the master modport is everything around it.
interface dmem_arbiter_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
);
  // CPU side: no handshake. cpu_req is honoured at once unless cpu_stall is high,
  // in which case the MEM stage holds its request and presents it again.
  logic            cpu_req;
  logic            cpu_we;
  logic [3:0]      cpu_be;
  logic [XLEN-3:0] cpu_addr;
  logic [XLEN-1:0] cpu_wd;
  logic [XLEN-1:0] cpu_rd;
  logic            cpu_stall;

  // EXT side valid/ready: a transfer happens on a cycle where ext_valid && ext_ready;
  // once ext_valid rises, ext_we/be/addr/wd stay stable and ext_valid stays high
  // until that cycle; ext_ready may depend combinationally on ext_valid.
  logic            ext_valid;
  logic            ext_ready;
  logic            ext_we;
  logic [3:0]      ext_be;
  logic [XLEN-3:0] ext_addr;
  logic [XLEN-1:0] ext_wd;
  logic            ext_rvalid;
  logic [XLEN-1:0] ext_rdata;

  logic            mem_we;
  logic [3:0]      mem_be;
  logic [XLEN-3:0] mem_addr;
  logic [XLEN-1:0] mem_wd;
  logic [XLEN-1:0] mem_rd;

  logic [CNT_W-1:0] conflict_cnt;

  modport slave (
    input  cpu_req, cpu_we, cpu_be, cpu_addr, cpu_wd,
    output cpu_rd, cpu_stall,
    input  ext_valid, ext_we, ext_be, ext_addr, ext_wd,
    output ext_ready, ext_rvalid, ext_rdata,
    output mem_we, mem_be, mem_addr, mem_wd,
    input  mem_rd,
    output conflict_cnt
  );

  modport master (
    output cpu_req, cpu_we, cpu_be, cpu_addr, cpu_wd,
    input  cpu_rd, cpu_stall,
    output ext_valid, ext_we, ext_be, ext_addr, ext_wd,
    input  ext_ready, ext_rvalid, ext_rdata,
    input  mem_we, mem_be, mem_addr, mem_wd,
    output mem_rd,
    input  conflict_cnt
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter: CPU has fixed priority, EXT gets a forced slot after
// MAX_WAIT consecutive losses. EXT reads return one cycle after grant.
module dmem_arbiter #(
  parameter int XLEN     = 32,
  parameter int MAX_WAIT = 4,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                reset,
  dmem_arbiter_if.slave       bus,
  output logic                dbg_force,
  output logic [7:0]          dbg_wait_cnt
);
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  typedef enum logic {S_NORMAL, S_FORCE} state_t;

  state_t           state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             ext_rvalid_q, ext_rvalid_d;
  logic [XLEN-1:0]  ext_rdata_q, ext_rdata_d;
  logic [CNT_W-1:0] conflict_cnt_q, conflict_cnt_d;
  logic             gnt_ext, gnt_cpu;

  always_comb begin
    if (state_q == S_FORCE) begin
      gnt_ext = bus.ext_valid;
      gnt_cpu = bus.cpu_req && !bus.ext_valid;
    end else begin
      gnt_ext = bus.ext_valid && !bus.cpu_req;
      gnt_cpu = bus.cpu_req;
    end
  end

  // A stalled CPU store never reaches memory: the write strobe follows the grant.
  always_comb begin
    bus.ext_ready = gnt_ext;
    bus.cpu_stall = bus.cpu_req && gnt_ext;
    bus.cpu_rd    = bus.mem_rd;
    bus.mem_we    = !reset && (gnt_ext ? bus.ext_we : (gnt_cpu && bus.cpu_we));
    bus.mem_be    = gnt_ext ? bus.ext_be : (gnt_cpu ? bus.cpu_be : 4'b0000);
    bus.mem_addr  = gnt_ext ? bus.ext_addr : bus.cpu_addr;
    bus.mem_wd    = gnt_ext ? bus.ext_wd : bus.cpu_wd;
  end

  always_comb begin
    state_d        = state_q;
    wait_cnt_d     = wait_cnt_q;
    ext_rvalid_d   = gnt_ext && !bus.ext_we;
    ext_rdata_d    = ext_rdata_q;
    conflict_cnt_d = conflict_cnt_q;

    if (gnt_ext || !bus.ext_valid) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q != WAIT_W'(MAX_WAIT)) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end

    case (state_q)
      S_NORMAL: if (bus.ext_valid && !gnt_ext && wait_cnt_q == WAIT_W'(MAX_WAIT - 1))
                  state_d = S_FORCE;
      S_FORCE:  if (gnt_ext || !bus.ext_valid)
                  state_d = S_NORMAL;
      default:  state_d = S_NORMAL;
    endcase

    // Read data is captured at the grant cycle, not at the response cycle.
    if (ext_rvalid_d) begin
      ext_rdata_d = bus.mem_rd;
    end

    if (bus.cpu_req && bus.ext_valid && conflict_cnt_q != '1) begin
      conflict_cnt_d = conflict_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= S_NORMAL;
      wait_cnt_q     <= '0;
      ext_rvalid_q   <= 1'b0;
      ext_rdata_q    <= '0;
      conflict_cnt_q <= '0;
    end else begin
      state_q        <= state_d;
      wait_cnt_q     <= wait_cnt_d;
      ext_rvalid_q   <= ext_rvalid_d;
      ext_rdata_q    <= ext_rdata_d;
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  assign bus.ext_rvalid   = ext_rvalid_q;
  assign bus.ext_rdata    = ext_rdata_q;
  assign bus.conflict_cnt = conflict_cnt_q;
  assign dbg_force        = (state_q == S_FORCE);
  assign dbg_wait_cnt     = 8'(wait_cnt_q);
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus random traffic checked against a
// loss-counting reference model, and a MAX_WAIT=1 / CNT_W=4 instance for alternation and saturation.
module tb_dmem_arbiter;
  localparam int MW_A  = 4;
  localparam int CMAXA = 65535;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.XLEN(32), .CNT_W(16)) ia ();
  dmem_arbiter_if #(.XLEN(32), .CNT_W(4))  ib ();

  logic       dbg_force_a, dbg_force_b;
  logic [7:0] dbg_wait_a, dbg_wait_b;

  dmem_arbiter #(.XLEN(32), .MAX_WAIT(MW_A), .CNT_W(16)) dut_a (
    .clk(clk), .reset(reset), .bus(ia.slave),
    .dbg_force(dbg_force_a), .dbg_wait_cnt(dbg_wait_a)
  );

  dmem_arbiter #(.XLEN(32), .MAX_WAIT(1), .CNT_W(4)) dut_b (
    .clk(clk), .reset(reset), .bus(ib.slave),
    .dbg_force(dbg_force_b), .dbg_wait_cnt(dbg_wait_b)
  );

  // Environment memory with combinational read, written on the rising edge.
  logic [31:0] mem_a [0:63];
  assign ia.mem_rd = mem_a[ia.mem_addr[5:0]];
  assign ib.mem_rd = 32'hCAFE_0000;

  always @(posedge clk) begin
    if (ia.mem_we) begin
      for (int b = 0; b < 4; b++)
        if (ia.mem_be[b]) mem_a[ia.mem_addr[5:0]][8*b +: 8] = ia.mem_wd[8*b +: 8];
    end
  end

  // Scoreboard counters and reference model state.
  int          total = 0;
  int          bad   = 0;
  logic [31:0] m_mem [0:63];
  int          m_losses;
  int          m_conf;
  logic        m_rv;
  logic [31:0] m_rd;
  logic [31:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: EXT wins when CPU is idle or EXT has already lost MAX_WAIT cycles in a row.
  always @(negedge clk) begin : cmp
    logic        e_gext, e_gcpu, e_we;
    logic [3:0]  e_be;
    logic [29:0] e_addr;
    logic [31:0] e_wd;
    if (reset) begin
      chk("rst_mem_we",   64'(ia.mem_we), 64'(0));
      chk("rst_rvalid",   64'(ia.ext_rvalid), 64'(0));
      chk("rst_conflict", 64'(ia.conflict_cnt), 64'(0));
      chk("rst_force",    64'(dbg_force_a), 64'(0));
      chk("rst_wait",     64'(dbg_wait_a), 64'(0));
      m_losses = 0;
      m_conf   = 0;
      m_rv     = 1'b0;
      m_rd     = 32'h0;
    end else begin
      e_gext = ia.ext_valid && (!ia.cpu_req || m_losses == MW_A);
      e_gcpu = ia.cpu_req && !e_gext;
      e_we   = e_gext ? ia.ext_we : (e_gcpu && ia.cpu_we);
      e_be   = e_gext ? ia.ext_be : (e_gcpu ? ia.cpu_be : 4'b0000);
      e_addr = e_gext ? ia.ext_addr : ia.cpu_addr;
      e_wd   = e_gext ? ia.ext_wd : ia.cpu_wd;

      chk("ext_ready",  64'(ia.ext_ready), 64'(e_gext));
      chk("cpu_stall",  64'(ia.cpu_stall), 64'(ia.cpu_req && e_gext));
      chk("mem_we",     64'(ia.mem_we), 64'(e_we));
      chk("mem_be",     64'(ia.mem_be), 64'(e_be));
      chk("ext_rvalid", 64'(ia.ext_rvalid), 64'(m_rv));
      chk("ext_rdata",  64'(ia.ext_rdata), 64'(m_rd));
      chk("conflict",   64'(ia.conflict_cnt), 64'(m_conf));
      chk("force",      64'(dbg_force_a), 64'(m_losses == MW_A));
      chk("wait_cnt",   64'(dbg_wait_a), 64'(m_losses));
      if (e_gext || e_gcpu) begin
        chk("mem_addr", 64'(ia.mem_addr), 64'(e_addr));
        chk("cpu_rd",   64'(ia.cpu_rd), 64'(m_mem[e_addr[5:0]]));
        if (e_we) chk("mem_wd", 64'(ia.mem_wd), 64'(e_wd));
      end

      m_rv = e_gext && !ia.ext_we;
      if (m_rv) m_rd = m_mem[e_addr[5:0]];
      if (e_we) begin
        for (int b = 0; b < 4; b++)
          if (e_be[b]) m_mem[e_addr[5:0]][8*b +: 8] = e_wd[8*b +: 8];
      end
      if (ia.ext_valid && !e_gext) m_losses = (m_losses < MW_A) ? m_losses + 1 : MW_A;
      else                         m_losses = 0;
      if (ia.cpu_req && ia.ext_valid && m_conf < CMAXA) m_conf++;
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
    #1;
  endtask

  task automatic set_cpu(input logic req, input logic we, input logic [3:0] be,
                         input logic [29:0] addr, input logic [31:0] wd);
    ia.cpu_req = req; ia.cpu_we = we; ia.cpu_be = be; ia.cpu_addr = addr; ia.cpu_wd = wd;
  endtask

  task automatic set_ext(input logic valid, input logic we, input logic [3:0] be,
                         input logic [29:0] addr, input logic [31:0] wd);
    ia.ext_valid = valid; ia.ext_we = we; ia.ext_be = be; ia.ext_addr = addr; ia.ext_wd = wd;
  endtask

  initial begin
    logic ext_acc;
    logic cpu_stl;
    reset = 1'b1;
    set_cpu(0, 0, 4'h0, 30'h0, 32'h0);
    set_ext(0, 0, 4'h0, 30'h0, 32'h0);
    ib.cpu_req = 0; ib.cpu_we = 0; ib.cpu_be = 4'hF; ib.cpu_addr = 30'h1; ib.cpu_wd = 32'h0;
    ib.ext_valid = 0; ib.ext_we = 0; ib.ext_be = 4'hF; ib.ext_addr = 30'h2; ib.ext_wd = 32'h0;
    for (int i = 0; i < 64; i++) begin
      mem_a[i] = $urandom;
      m_mem[i] = mem_a[i];
    end
    mem_a[0]  = 32'h4433_2211; m_mem[0]  = 32'h4433_2211;
    mem_a[16] = 32'hDEAD_BEEF; m_mem[16] = 32'hDEAD_BEEF;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // EXT-only read: accepted at once, data one cycle later.
    set_ext(1, 0, 4'hF, 30'h10, 32'h0);
    mid();
    chk("t1_ready", 64'(ia.ext_ready), 64'(1));
    chk("t1_stall", 64'(ia.cpu_stall), 64'(0));
    next_cycle();
    set_ext(0, 0, 4'h0, 30'h0, 32'h0);
    mid();
    chk("t1_rvalid", 64'(ia.ext_rvalid), 64'(1));
    chk("t1_rdata",  64'(ia.ext_rdata), 64'h0000_0000_DEAD_BEEF);
    next_cycle();

    // Held contention: forced EXT slot on cycle 4.
    set_cpu(1, 0, 4'hF, 30'h1, 32'h0);
    set_ext(1, 0, 4'hF, 30'h2, 32'h0);
    for (int c = 0; c < 6; c++) begin
      mid();
      chk("t2_ready", 64'(ia.ext_ready), 64'(c == 4));
      chk("t2_stall", 64'(ia.cpu_stall), 64'(c == 4));
      next_cycle();
    end
    set_cpu(0, 0, 4'h0, 30'h0, 32'h0);
    set_ext(0, 0, 4'h0, 30'h0, 32'h0);
    mid();
    chk("t2_conflict", 64'(ia.conflict_cnt), 64'(6));
    next_cycle();

    // Stalled CPU store must not land during the forced EXT write.
    set_cpu(1, 1, 4'hF, 30'h20, 32'h1111_1111);
    set_ext(1, 1, 4'hF, 30'h20, 32'h2222_2222);
    for (int c = 0; c < 5; c++) begin
      mid();
      chk("t3_stall", 64'(ia.cpu_stall), 64'(c == 4));
      next_cycle();
    end
    set_ext(0, 0, 4'h0, 30'h0, 32'h0);
    mid();
    chk("t3_mem_ext", 64'(mem_a[32]), 64'h0000_0000_2222_2222);
    chk("t3_mem_we",  64'(ia.mem_we), 64'(1));
    next_cycle();
    set_cpu(0, 0, 4'h0, 30'h0, 32'h0);
    mid();
    chk("t3_mem_cpu", 64'(mem_a[32]), 64'h0000_0000_1111_1111);
    next_cycle();

    // Byte-lane write from EXT during a stalled CPU load.
    set_cpu(1, 0, 4'hF, 30'h5, 32'h0);
    set_ext(1, 1, 4'b0100, 30'h0, 32'h00AB_0000);
    for (int c = 0; c < 5; c++) begin
      mid();
      chk("t4_stall", 64'(ia.cpu_stall), 64'(c == 4));
      if (c == 4) chk("t4_mem_be", 64'(ia.mem_be), 64'(4'b0100));
      next_cycle();
    end
    set_cpu(0, 0, 4'h0, 30'h0, 32'h0);
    set_ext(0, 0, 4'h0, 30'h0, 32'h0);
    mid();
    chk("t4_word0", 64'(mem_a[0]), 64'h0000_0000_44AB_2211);
    next_cycle();

    // Reset right after an EXT read grant discards the response.
    set_ext(1, 0, 4'hF, 30'h10, 32'h0);
    mid();
    chk("t5_grant", 64'(ia.ext_ready), 64'(1));
    next_cycle();
    set_cpu(1, 1, 4'hF, 30'h3, 32'h5555_5555);
    set_ext(1, 0, 4'hF, 30'h4, 32'h0);
    reset = 1'b1;
    mid();
    chk("t5_rvalid",   64'(ia.ext_rvalid), 64'(0));
    chk("t5_force",    64'(dbg_force_a), 64'(0));
    chk("t5_wait",     64'(dbg_wait_a), 64'(0));
    chk("t5_conflict", 64'(ia.conflict_cnt), 64'(0));
    chk("t5_mem_we",   64'(ia.mem_we), 64'(0));
    next_cycle();
    reset = 1'b0;
    set_cpu(0, 0, 4'h0, 30'h0, 32'h0);
    set_ext(0, 0, 4'h0, 30'h0, 32'h0);
    next_cycle();

    // Random traffic, EXT and stalled CPU hold their payloads until served.
    ext_acc = 1'b1;
    cpu_stl = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 399) == 0);
      if (!ia.ext_valid || ext_acc) begin
        set_ext($urandom_range(0, 99) < 55, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                30'($urandom_range(0, 15)), $urandom);
      end
      if (!(ia.cpu_req && cpu_stl)) begin
        set_cpu($urandom_range(0, 99) < 70, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                30'($urandom_range(0, 15)), $urandom);
      end
      mid();
      ext_acc = ia.ext_ready;
      cpu_stl = ia.cpu_stall;
      next_cycle();
    end
    reset = 1'b0;
    set_cpu(0, 0, 4'h0, 30'h0, 32'h0);
    set_ext(0, 0, 4'h0, 30'h0, 32'h0);
    next_cycle();

    for (int i = 0; i < 64; i++) exp_q.push_back(m_mem[i]);
    for (int i = 0; i < 64; i++) chk("mem_word", 64'(mem_a[i]), 64'(exp_q.pop_front()));

    // MAX_WAIT=1 alternates under contention; 4-bit counter saturates at 15.
    ib.cpu_req = 1'b1;
    ib.ext_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      mid();
      chk("b_ready",    64'(ib.ext_ready), 64'(c % 2 == 1));
      chk("b_conflict", 64'(ib.conflict_cnt), 64'((c < 15) ? c : 15));
      next_cycle();
    end
    ib.cpu_req = 1'b0;
    ib.ext_valid = 1'b0;
    mid();
    chk("b_sat", 64'(ib.conflict_cnt), 64'(15));
    next_cycle();
    mid();
    chk("b_sat_hold", 64'(ib.conflict_cnt), 64'(15));
    next_cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
